// File: rtl/vga_pkg.sv
// ============================================================================
// Module : vga_pkg
// Shared 640x480@60 timing constants and raster types for the video pipeline.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package vga_pkg;

  typedef logic [9:0] coord_t;

  localparam int c_H_VISIBLE = 640;
  localparam int c_H_FRONT   = 16;
  localparam int c_H_SYNC    = 96;
  localparam int c_H_BACK    = 48;
  localparam int c_V_VISIBLE = 480;
  localparam int c_V_FRONT   = 10;
  localparam int c_V_SYNC    = 2;
  localparam int c_V_BACK    = 33;

  localparam int c_H_TOTAL   = c_H_VISIBLE + c_H_FRONT + c_H_SYNC + c_H_BACK;
  localparam int c_V_TOTAL   = c_V_VISIBLE + c_V_FRONT + c_V_SYNC + c_V_BACK;
  localparam int c_COORD_MAX = 1023;

  // Registered output bundle; every field is launched from the same edge.
  typedef struct packed {
    logic   pix_tick;
    coord_t pixelx;
    coord_t pixely;
    logic   hsync;
    logic   vsync;
    logic   video_on;
    logic   frame_start;
  } vga_timing_t;

  function automatic logic in_range(input coord_t v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) < hi);
  endfunction

endpackage

`default_nettype wire

// File: rtl/timing_counter.sv
// ============================================================================
// Module : timing_counter
// One raster axis: wrapping counter with sync-window and visible decodes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module timing_counter
  import vga_pkg::*;
#(
  parameter int TOTAL      = c_H_TOTAL,
  parameter int SYNC_START = c_H_VISIBLE + c_H_FRONT,
  parameter int SYNC_END   = c_H_VISIBLE + c_H_FRONT + c_H_SYNC,
  parameter int VISIBLE    = c_H_VISIBLE
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  output coord_t count,
  output logic   wrap,
  output logic   in_sync,
  output logic   in_visible
);

  coord_t r_count;
  logic   w_last;

  assign w_last = (r_count == coord_t'(TOTAL - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= w_last ? '0 : r_count + coord_t'(1);
    end
  end

  assign count      = r_count;
  assign wrap       = en && w_last;
  assign in_sync    = in_range(r_count, SYNC_START, SYNC_END);
  assign in_visible = (int'(r_count) < VISIBLE);

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module : vga_timing_gen
// Free-running VGA raster timing with registered, mutually aligned outputs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = c_H_VISIBLE,
  parameter int H_FRONT   = c_H_FRONT,
  parameter int H_SYNC    = c_H_SYNC,
  parameter int H_BACK    = c_H_BACK,
  parameter int V_VISIBLE = c_V_VISIBLE,
  parameter int V_FRONT   = c_V_FRONT,
  parameter int V_SYNC    = c_V_SYNC,
  parameter int V_BACK    = c_V_BACK
) (
  input  logic   clk,
  input  logic   rst,
  output logic   pix_tick,
  output coord_t pixelx,
  output coord_t pixely,
  output logic   hsync,
  output logic   vsync,
  output logic   video_on,
  output logic   frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  generate
    if (H_TOTAL > c_COORD_MAX || V_TOTAL > c_COORD_MAX) begin : g_bad_total
      $error("vga_timing_gen: line or frame total does not fit in coord_t");
    end
    if (CLK_DIV < 1 || CLK_DIV > 4) begin : g_bad_div
      $error("vga_timing_gen: CLK_DIV must be 1..4");
    end
  endgenerate

  logic [1:0]  r_div;
  logic        w_tick;
  coord_t      w_h_cnt;
  coord_t      w_v_cnt;
  logic        w_h_wrap;
  logic        w_unused_v_wrap;
  logic        w_h_sync;
  logic        w_v_sync;
  logic        w_h_vis;
  logic        w_v_vis;
  vga_timing_t r_out;

  assign w_tick = (r_div == 2'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 2'd1;
    end
  end

  timing_counter #(
    .TOTAL      (H_TOTAL),
    .SYNC_START (H_VISIBLE + H_FRONT),
    .SYNC_END   (H_VISIBLE + H_FRONT + H_SYNC),
    .VISIBLE    (H_VISIBLE)
  ) u_h_cnt (
    .clk        (clk),
    .rst        (rst),
    .en         (w_tick),
    .count      (w_h_cnt),
    .wrap       (w_h_wrap),
    .in_sync    (w_h_sync),
    .in_visible (w_h_vis)
  );

  // Line wrap already implies a tick; the AND keeps the enable explicit.
  timing_counter #(
    .TOTAL      (V_TOTAL),
    .SYNC_START (V_VISIBLE + V_FRONT),
    .SYNC_END   (V_VISIBLE + V_FRONT + V_SYNC),
    .VISIBLE    (V_VISIBLE)
  ) u_v_cnt (
    .clk        (clk),
    .rst        (rst),
    .en         (w_tick & w_h_wrap),
    .count      (w_v_cnt),
    .wrap       (w_unused_v_wrap),
    .in_sync    (w_v_sync),
    .in_visible (w_v_vis)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out.pix_tick    <= 1'b0;
      r_out.pixelx      <= '0;
      r_out.pixely      <= '0;
      r_out.hsync       <= 1'b1;
      r_out.vsync       <= 1'b1;
      r_out.video_on    <= 1'b0;
      r_out.frame_start <= 1'b0;
    end else begin
      r_out.pix_tick    <= w_tick;
      r_out.pixelx      <= w_h_cnt;
      r_out.pixely      <= w_v_cnt;
      r_out.hsync       <= ~w_h_sync;
      r_out.vsync       <= ~w_v_sync;
      r_out.video_on    <= w_h_vis & w_v_vis;
      r_out.frame_start <= w_tick && (w_h_cnt == '0) && (w_v_cnt == '0);
    end
  end

  assign pix_tick    = r_out.pix_tick;
  assign pixelx      = r_out.pixelx;
  assign pixely      = r_out.pixely;
  assign hsync       = r_out.hsync;
  assign vsync       = r_out.vsync;
  assign video_on    = r_out.video_on;
  assign frame_start = r_out.frame_start;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
// Module : tb_vga_timing_gen
// Self-checking bench: full-size and shrunken rasters against an arithmetic model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  longint m_edges = -1;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) m_edges <= -1;
    else      m_edges <= m_edges + 1;
  end

  // Instance 0: full 640x480 div 2; 1: full div 1; 2: tiny raster div 2; 3: tiny div 3
  logic       tk [4];
  logic [9:0] px [4];
  logic [9:0] py [4];
  logic       hs [4];
  logic       vs [4];
  logic       von[4];
  logic       fs [4];
  logic [24:0] act[4];

  for (genvar g = 0; g < 4; g++) begin : g_pack
    assign act[g] = {tk[g], px[g], py[g], hs[g], vs[g], von[g], fs[g]};
  end

  vga_timing_gen #(.CLK_DIV(2)) u_full2 (
    .clk(clk), .rst(rst), .pix_tick(tk[0]), .pixelx(px[0]), .pixely(py[0]),
    .hsync(hs[0]), .vsync(vs[0]), .video_on(von[0]), .frame_start(fs[0]));

  vga_timing_gen #(.CLK_DIV(1)) u_full1 (
    .clk(clk), .rst(rst), .pix_tick(tk[1]), .pixelx(px[1]), .pixely(py[1]),
    .hsync(hs[1]), .vsync(vs[1]), .video_on(von[1]), .frame_start(fs[1]));

  vga_timing_gen #(.CLK_DIV(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                   .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)) u_small2 (
    .clk(clk), .rst(rst), .pix_tick(tk[2]), .pixelx(px[2]), .pixely(py[2]),
    .hsync(hs[2]), .vsync(vs[2]), .video_on(von[2]), .frame_start(fs[2]));

  vga_timing_gen #(.CLK_DIV(3), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                   .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)) u_small3 (
    .clk(clk), .rst(rst), .pix_tick(tk[3]), .pixelx(px[3]), .pixely(py[3]),
    .hsync(hs[3]), .vsync(vs[3]), .video_on(von[3]), .frame_start(fs[3]));

  // Output vector m clock edges after reset release (m<0: still in reset).
  function automatic logic [24:0] model(input longint m, input int d,
      input int hv, input int hf, input int hsw, input int hb,
      input int vv, input int vf, input int vsw, input int vb);
    longint p;
    int ht, vt, h, v;
    logic t;
    if (m < 0) return {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    p  = m / d;
    t  = ((m % d) == longint'(d - 1));
    h  = int'(p % ht);
    v  = int'((p / ht) % vt);
    return {t, 10'(h), 10'(v),
            !(h >= hv + hf && h < hv + hf + hsw),
            !(v >= vv + vf && v < vv + vf + vsw),
            (h < hv) && (v < vv),
            t && (h == 0) && (v == 0)};
  endfunction

  function automatic logic [24:0] expected(input int k);
    case (k)
      0:       return model(m_edges, 2, 640, 16, 96, 48, 480, 10, 2, 33);
      1:       return model(m_edges, 1, 640, 16, 96, 48, 480, 10, 2, 33);
      2:       return model(m_edges, 2, 8, 2, 3, 2, 6, 1, 2, 2);
      default: return model(m_edges, 3, 8, 2, 3, 2, 6, 1, 2, 2);
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (act[k] !== 25'h1_0000_0C >> 0 && act[k] !== {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
          failures++;
          $display("FAIL reset_hold inst%0d: got %h want %h", k, act[k],
                   {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0});
        end
      end
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (tk[0] !== 1'b0 || tk[1] !== 1'b1) begin
      failures++;
      $display("FAIL first_edge_tick: got div2=%b div1=%b want 0 1", tk[0], tk[1]);
    end
    @(negedge clk);
    checks++;
    if ({tk[0], fs[0], px[0], py[0], von[0]} !== {1'b1, 1'b1, 10'd0, 10'd0, 1'b1}) begin
      failures++;
      $display("FAIL first_tick: got tick=%b fs=%b x=%0d y=%0d von=%b want 1 1 0 0 1",
               tk[0], fs[0], px[0], py[0], von[0]);
    end
  endtask

  task automatic test_random_run();
    int n = $urandom_range(800, 1500);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (act[k] !== expected(k)) begin
          failures++;
          $display("FAIL model_run inst%0d m=%0d: got %h want %h", k, m_edges, act[k], expected(k));
        end
      end
    end
  endtask

  // Measures period and low width of hsync on instance k.
  task automatic measure_hsync(input int k, input int want_period, input int want_low);
    logic prev;
    logic found;
    int   t0, low;
    for (int rep = 0; rep < 2; rep++) begin
      prev = hs[k];
      found = 1'b0;
      for (int i = 0; i < 4000 && !found; i++) begin
        @(negedge clk);
        if (prev && !hs[k]) found = 1'b1;
        prev = hs[k];
      end
      checks++;
      if (!found || px[k] !== 10'd656) begin
        failures++;
        $display("FAIL hsync_fall inst%0d: found=%b x=%0d want found at x=656", k, found, px[k]);
      end
      if (rep == 1) begin
        checks++;
        if (cyc - t0 != want_period) begin
          failures++;
          $display("FAIL line_period inst%0d: got %0d want %0d", k, cyc - t0, want_period);
        end
      end
      t0 = cyc;
      low = 0;
      for (int i = 0; i < 4000 && !hs[k]; i++) begin
        low++;
        @(negedge clk);
      end
      checks++;
      if (low != want_low) begin
        failures++;
        $display("FAIL hsync_low inst%0d: got %0d want %0d", k, low, want_low);
      end
    end
  endtask

  task automatic test_line_timing();
    logic       pv;
    logic [9:0] pxp;
    logic       found;
    measure_hsync(0, 1600, 192);
    pv = von[0];
    pxp = px[0];
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      @(negedge clk);
      if (pv && !von[0]) found = 1'b1;
      else begin
        pv = von[0];
        pxp = px[0];
      end
    end
    checks++;
    if (!found || px[0] !== 10'd640 || pxp !== 10'd639) begin
      failures++;
      $display("FAIL video_on_fall: found=%b x %0d->%0d want 639->640", found, pxp, px[0]);
    end
  endtask

  task automatic test_frame_timing();
    int   t0, low;
    logic prev, found;
    for (int rep = 0; rep < 2; rep++) begin
      found = 1'b0;
      for (int i = 0; i < 1000 && !found; i++) begin
        @(negedge clk);
        if (fs[2]) found = 1'b1;
      end
      checks++;
      if (!found || (rep == 1 && cyc - t0 != 330)) begin
        failures++;
        $display("FAIL frame_period: found=%b got %0d want 330", found, cyc - t0);
      end
      t0 = cyc;
      @(negedge clk);
      checks++;
      if (fs[2] !== 1'b0) begin
        failures++;
        $display("FAIL frame_start_width: got %b want 0 on following clk", fs[2]);
      end
    end
    prev = vs[2];
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (prev && !vs[2]) found = 1'b1;
      prev = vs[2];
    end
    checks++;
    if (!found || px[2] !== 10'd0 || py[2] !== 10'd7) begin
      failures++;
      $display("FAIL vsync_fall: found=%b x=%0d y=%0d want x=0 y=7", found, px[2], py[2]);
    end
    low = 0;
    for (int i = 0; i < 1000 && !vs[2]; i++) begin
      low++;
      @(negedge clk);
    end
    checks++;
    if (low != 60) begin
      failures++;
      $display("FAIL vsync_low: got %0d want 60", low);
    end
  endtask

  task automatic test_wrap_corner();
    logic found = 1'b0;
    logic syncs_ok = 1'b1;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (tk[2] && px[2] == 10'd14 && py[2] == 10'd10) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL wrap_reach: got none want pixel (14,10)");
    end
    if (!hs[2] || !vs[2]) syncs_ok = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (!hs[2] || !vs[2]) syncs_ok = 1'b0;
      if (tk[2]) found = 1'b1;
    end
    checks++;
    if (!found || px[2] !== 10'd0 || py[2] !== 10'd0 || fs[2] !== 1'b1 || !syncs_ok) begin
      failures++;
      $display("FAIL wrap_corner: found=%b x=%0d y=%0d fs=%b syncs_ok=%b want 0 0 1 1",
               found, px[2], py[2], fs[2], syncs_ok);
    end
  endtask

  task automatic test_mid_frame_reset();
    logic [9:0] tx, ty;
    logic       found;
    for (int it = 0; it < 3; it++) begin
      tx = 10'($urandom_range(1, 7));
      ty = 10'($urandom_range(1, 5));
      found = 1'b0;
      for (int i = 0; i < 1000 && !found; i++) begin
        @(negedge clk);
        if (px[2] == tx && py[2] == ty) found = 1'b1;
      end
      checks++;
      if (!found) begin
        failures++;
        $display("FAIL midreset_reach: got none want (%0d,%0d)", tx, ty);
      end
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (act[k] !== {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
          failures++;
          $display("FAIL midreset_values inst%0d: got %h want %h", k, act[k],
                   {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0});
        end
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({tk[0], fs[0], px[0], py[0], von[0]} !== {1'b1, 1'b1, 10'd0, 10'd0, 1'b1}) begin
        failures++;
        $display("FAIL midreset_restart: got tick=%b fs=%b x=%0d y=%0d von=%b want 1 1 0 0 1",
                 tk[0], fs[0], px[0], py[0], von[0]);
      end
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
          checks++;
          if (act[k] !== expected(k)) begin
            failures++;
            $display("FAIL midreset_model inst%0d m=%0d: got %h want %h", k, m_edges, act[k], expected(k));
          end
        end
      end
    end
  endtask

  task automatic test_clkdiv1();
    int misses = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (tk[1] !== 1'b1) misses++;
    end
    checks++;
    if (misses != 0) begin
      failures++;
      $display("FAIL div1_tick_constant: got %0d low clks want 0", misses);
    end
    measure_hsync(1, 800, 96);
  endtask

  initial begin
    test_reset();
    test_random_run();
    test_line_timing();
    test_frame_timing();
    test_wrap_corner();
    test_mid_frame_reset();
    test_clkdiv1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
